// File: rtl/core_padport.sv
// Joypad port responder for $4016/$4017: synchronises and debounces the raw
// buttons, applies optional A/B turbo, and serialises one bit per CPU read.
module core_padport #(
  parameter int unsigned DEB_CYCLES = 16'd50000,
  parameter int          DEB_W      = 16,
  parameter int unsigned TURBO_DIV  = 2
) (
  input  logic       I_clock,
  input  logic       I_reset,
  input  logic       I_strobe,
  input  logic [1:0] I_rden,
  output logic [1:0] O_data,
  input  logic [7:0] I_buttons0,
  input  logic [7:0] I_buttons1,
  input  logic [1:0] I_turbo_en0,
  input  logic [1:0] I_turbo_en1
);

  localparam int                 TURBO_W   = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;
  localparam logic [DEB_W-1:0]   DEB_MAX   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [TURBO_W-1:0] TURBO_MAX = TURBO_W'(TURBO_DIV - 1);

  logic [1:0][7:0]         buttons;
  logic [1:0][1:0]         turbo_en;
  logic [1:0][7:0]         sync1;
  logic [1:0][7:0]         sync2;
  logic [1:0][7:0]         stable;
  logic [1:0][7:0]         effective;
  logic [1:0][7:0]         shift;
  logic [1:0][DEB_W-1:0]   deb_cnt;
  logic [1:0][TURBO_W-1:0] turbo_cnt;
  logic [1:0]              phase;
  logic [1:0]              last_rden;
  logic                    last_strobe;
  logic                    strobe_fall;
  logic [1:0]              rden_fall;

  assign buttons     = {I_buttons1, I_buttons0};
  assign turbo_en    = {I_turbo_en1, I_turbo_en0};
  assign strobe_fall = last_strobe & ~I_strobe;
  assign rden_fall   = last_rden & ~I_rden;
  assign O_data      = {shift[1][0], shift[0][0]};

  // Turbo masks A/B with the phase; phase is only ever consulted while latching.
  always_comb begin
    effective = stable;
    for (int p = 0; p < 2; p++) begin
      effective[p][0] = stable[p][0] & (~turbo_en[p][0] | phase[p]);
      effective[p][1] = stable[p][1] & (~turbo_en[p][1] | phase[p]);
    end
  end

  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      sync1       <= '0;
      sync2       <= '0;
      stable      <= '0;
      shift       <= '0;
      deb_cnt     <= '0;
      turbo_cnt   <= '0;
      phase       <= 2'b11;
      last_rden   <= '0;
      last_strobe <= 1'b0;
    end else begin
      last_strobe <= I_strobe;
      last_rden   <= I_rden;
      for (int p = 0; p < 2; p++) begin
        sync1[p] <= buttons[p];
        sync2[p] <= sync1[p];

        // The counter restarts one clock before sync2 changes, so a saturated
        // counter can never let a fresh glitch straight into stable.
        if (sync1[p] != sync2[p])
          deb_cnt[p] <= '0;
        else if (deb_cnt[p] != DEB_MAX)
          deb_cnt[p] <= deb_cnt[p] + DEB_W'(1);
        if (deb_cnt[p] == DEB_MAX)
          stable[p] <= sync2[p];

        if (strobe_fall) begin
          if (turbo_cnt[p] == TURBO_MAX) begin
            turbo_cnt[p] <= '0;
            phase[p]     <= ~phase[p];
          end else begin
            turbo_cnt[p] <= turbo_cnt[p] + TURBO_W'(1);
          end
        end

        // Ones shift in from the top so reads past the eighth return 1.
        if (I_strobe)
          shift[p] <= effective[p];
        else if (rden_fall[p])
          shift[p] <= {1'b1, shift[p][7:1]};
      end
    end
  end

endmodule

// File: doc/core_padport.md
Name: core_padport

Overview:
- Controller-side responder for the two joypad ports behind $4016/$4017.
- Takes the strobe latch bit and per-port read pulses from the CPU core, and returns one serial button bit per port per read, as a standard 8-bit parallel-in/serial-out pad does.
- Raw button inputs are synchronised and debounced; per-port turbo can be enabled on A and B.
- Sits beside the core at board level: I_strobe from GPIO latch bit 0, I_rden from the GPIO read-enable pair, O_data to the GPIO read-data pair.

Parameters:
DEB_CYCLES, 16'd50000, consecutive clocks a synchronised button vector must stay unchanged before it becomes the stable state (min 1)
DEB_W, 16, width of the debounce counter
TURBO_DIV, 2, strobe falling edges per turbo phase toggle (min 1)

Ports:
I_clock  in  1  system clock
I_reset  in  1  synchronous, active-high reset
I_strobe  in  1  latch level (GPIO data bit 0 written to $4016)
I_rden  in  2  per-port read enable, high during phy2 of a $4016 ([0]) / $4017 ([1]) read
O_data  out  2  per-port serial button bit, 1 = pressed
I_buttons0  in  8  port 0 raw buttons, async, 1 = pressed; bits 0..7 = A,B,Select,Start,Up,Down,Left,Right
I_buttons1  in  8  port 1 raw buttons, same encoding
I_turbo_en0  in  2  port 0 turbo enable: [0] = A, [1] = B
I_turbo_en1  in  2  port 1 turbo enable, same encoding

Behaviour:
- Reset (I_reset high at a clock edge), all registers:
  - sync stages, stable vectors, debounce counters, turbo counters, last_rden, last_strobe, shift registers <= 0
  - turbo phase <= 1
  - O_data = 2'b00 from the next cycle.
- Reset mid-read discards the shift contents; port state is valid again only after the next strobe.
- Sync: 2-flop synchroniser on every raw button bit.
- Debounce (per port, one counter for the 8-bit vector):
  - Synchronised vector differs from the previous synchronised value -> counter <= 0.
  - Otherwise counter increments and saturates at DEB_CYCLES-1.
  - While counter == DEB_CYCLES-1: stable <= synchronised vector.
  - A glitch shorter than DEB_CYCLES clocks never reaches stable.
  - With DEB_CYCLES = 1, stable follows the sync output with 1 clock extra latency.
- Turbo (per port):
  - Counter increments on each strobe falling edge (last_strobe & ~I_strobe).
  - On reaching TURBO_DIV-1 it wraps to 0 and the phase toggles.
  - Effective A = stable A & (~turbo_en[0] | phase); effective B likewise with turbo_en[1].
  - Other bits = stable.
- Shift register (per port, 8 bits):
  - I_strobe high: shift <= effective vector on every clock (continuous reload), so O_data tracks live A.
  - I_strobe low and falling edge of I_rden[n] (last_rden[n] & ~I_rden[n]): shift <= {1'b1, shift[7:1]}.
  - O_data[n] = shift[0], direct from the register with no combinational path from inputs, so the bit is stable for the whole read and advances after it.
- Read sequence: reads 1..8 return A,B,Select,Start,Up,Down,Left,Right; read 9 and later return 1 until the next strobe.
- Simultaneous events:
  - Strobe high together with a rden fall: reload wins, no shift.
  - rden held high over several clocks counts as one read.
  - Ports are fully independent; both may shift on the same clock.
  - Strobe fall and latch on the same clock: the latch uses the pre-toggle turbo phase.

Test Plan:
1. DEB_CYCLES=1, I_buttons0=8'h81, hold 4 clk, strobe high 2 clk then low, 10 rden[0] pulses -> O_data[0] per read 1,0,0,0,0,0,0,1,1,1; O_data[1]=0 throughout.
2. Strobe held high, I_buttons0 A toggled, 3 rden[0] pulses -> O_data[0] follows A (after sync+debounce latency +1 clk), no shift; after strobe low, first read returns current A.
3. DEB_CYCLES=4: bit 3 pulsed high for 3 clk -> stable and read value unchanged (0); held 8 clk -> Start read as 1 on read 4 of the next frame.
4. TURBO_DIV=2, turbo_en0=2'b01, A held, 6 strobe frames each read once -> A values 1,1,0,0,1,1; with turbo_en0=0 -> all 1.
5. Port independence: I_buttons1=8'h02, 3 rden[1] pulses only -> O_data[1] 0,1,0; port 0 shift untouched (O_data[0] still A).
6. Reset asserted after 3 shifts on port 0 -> O_data=00 next clk; after release, strobe frame with I_buttons0=8'h01 -> reads 1,0,...,0 then 1s.
